// File: rtl/fifo_width_serializer.sv
// fifo_width_serializer
//
// Purpose:
//   Sits downstream of a FIFO. It dequeues one wide word (inWidth bits) and
//   sends it on as ratio = inWidth/outWidth narrow beats, least significant
//   slice first, into the next stage's enqueue interface. When the next word is
//   already waiting, the serializer reloads on the final beat of the current
//   word. This lets consecutive words stream at one beat per cycle with no gap.
//
// Ports:
//   CLK         in   clock; all state updates on the rising edge
//   nRST        in   synchronous reset, active-low
//   inDeqEna    out  dequeue strobe to the upstream FIFO
//   inDeqRdy    in   upstream FIFO is non-empty
//   inFirst     in   upstream head word [inWidth]
//   inFirstRdy  in   head word valid (ANDed with inDeqRdy)
//   outEnqEna   out  beat enqueue strobe to the next stage
//   outEnqV     out  beat data [outWidth]
//   outEnqRdy   in   next stage can accept a beat
//   outEnqLast  out  final beat of a word (only with SERIALIZER_LAST_EN)
//
// Configuration:
//   SERIALIZER_LAST_EN  when defined, adds the outEnqLast port.

module fifo_width_serializer #(
  parameter int inWidth  = 128,
  parameter int outWidth = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  output logic                inDeqEna,
  input  logic                inDeqRdy,
  input  logic [inWidth-1:0]  inFirst,
  input  logic                inFirstRdy,
  output logic                outEnqEna,
  output logic [outWidth-1:0] outEnqV,
  input  logic                outEnqRdy
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                outEnqLast
`endif
);

  localparam int RATIO = inWidth / outWidth;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((inWidth % outWidth) != 0 || RATIO < 2) begin : g_bad_widths
    $error("fifo_width_serializer: inWidth must be a multiple of outWidth with ratio >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              st, st_next;
  logic [inWidth-1:0]  sh, sh_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic                avail;
  logic                last_beat;

  assign avail     = inDeqRdy & inFirstRdy;
  assign last_beat = (st == SHIFT) && (cnt == CW'(RATIO - 1));

  // The strobes are gated by nRST, so no handshake can complete during the
  // reset cycle. A dequeue in SHIFT only happens when the last beat actually
  // leaves. This reload path gives zero-bubble streaming between words.
  assign outEnqEna = nRST & (st == SHIFT) & outEnqRdy;
  assign inDeqEna  = nRST & avail & ((st == IDLE) | (last_beat & outEnqRdy));
  assign outEnqV   = nRST ? sh[outWidth-1:0] : '0;

`ifdef SERIALIZER_LAST_EN
  assign outEnqLast = nRST & last_beat;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      st  <= IDLE;
      sh  <= '0;
      cnt <= '0;
    end else begin
      st  <= st_next;
      sh  <= sh_next;
      cnt <= cnt_next;
    end
  end

  // A stall (outEnqRdy low) falls through with every register held.
  // On an accepted beat, the register shifts down and fills with zeros.
  // On the final beat, it reloads the next word if one is being dequeued;
  // otherwise it returns to IDLE.
  always_comb begin
    st_next  = st;
    sh_next  = sh;
    cnt_next = cnt;
    case (st)
      IDLE: begin
        if (inDeqEna) begin
          sh_next  = inFirst;
          cnt_next = '0;
          st_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (outEnqEna) begin
          if (!last_beat) begin
            sh_next  = sh >> outWidth;
            cnt_next = cnt + 1'b1;
          end else if (inDeqEna) begin
            sh_next  = inFirst;
            cnt_next = '0;
          end else begin
            st_next  = IDLE;
            cnt_next = '0;
          end
        end
      end
      default: begin
        st_next  = IDLE;
        cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_width_serializer.sv
// tb_fifo_width_serializer
//
// Bench for fifo_width_serializer at 128 -> 32 bits. It contains a queue-based
// model of the upstream FIFO. Expected beats are queued as each word is offered.
// A monitor pops one expected beat for each beat that the DUT enqueues.

module tb_fifo_width_serializer;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int RATIO = IN_W / OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  logic             clk = 1'b0;
  logic             nrst;
  logic             deq_ena;
  logic             deq_rdy;
  logic [IN_W-1:0]  first_word;
  logic             first_rdy;
  logic             enq_ena;
  logic [OUT_W-1:0] enq_v;
  logic             enq_rdy;
`ifdef SERIALIZER_LAST_EN
  logic             enq_last;
`endif

  beat_t           exp_q[$];
  logic [IN_W-1:0] up_q[$];
  int              beat_cyc[$];
  int              deq_cyc[$];
  int              assert_cnt = 0;
  int              fail_cnt   = 0;
  int              cyc        = 0;
  int              beats_seen = 0;
  bit              deq_flag   = 1'b0;
  bit              rand_mode  = 1'b0;
  bit              up_en      = 1'b1;

  always #5 clk = ~clk;

  fifo_width_serializer #(
    .inWidth (IN_W),
    .outWidth(OUT_W)
  ) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .inDeqEna  (deq_ena),
    .inDeqRdy  (deq_rdy),
    .inFirst   (first_word),
    .inFirstRdy(first_rdy),
    .outEnqEna (enq_ena),
    .outEnqV   (enq_v),
    .outEnqRdy (enq_rdy)
`ifdef SERIALIZER_LAST_EN
    ,
    .outEnqLast(enq_last)
`endif
  );

  task automatic checkOutput(input string name, input logic [IN_W-1:0] actual,
                             input logic [IN_W-1:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Offer a word to the upstream FIFO model and queue its beats, low slice first.
  task automatic applyStimulus(input logic [IN_W-1:0] w);
    beat_t b;
    up_q.push_back(w);
    for (int i = 0; i < RATIO; i++) begin
      b.data = w[i*OUT_W +: OUT_W];
      b.last = (i == RATIO - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic waitBeats(input int n, input int budget);
    int k = 0;
    while (beats_seen < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    checkOutput("beats_within_budget", beats_seen >= n, 1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Upstream FIFO model and random ready generation. It pops on the edge
  // following a sampled dequeue, then re-drives the head #1 after the edge.
  initial begin
    deq_rdy    = 1'b0;
    first_word = '0;
    first_rdy  = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (deq_flag && up_q.size() > 0) void'(up_q.pop_front());
      #1;
      if (rand_mode) begin
        enq_rdy   = 1'($urandom_range(0, 1));
        up_en     = 1'($urandom_range(0, 1));
        first_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        first_rdy = 1'b1;
      end
      deq_rdy    = up_en && (up_q.size() > 0);
      first_word = (up_q.size() > 0) ? up_q[0] : '0;
    end
  end

  // Monitor: this process samples on the falling edge and checks every beat
  // that will be accepted on the next rising edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      deq_flag = deq_ena;
      if (deq_ena) deq_cyc.push_back(cyc);
      if (enq_ena) begin
        checkOutput("ena_needs_rdy", enq_rdy, 1);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", enq_v, 0);
          if (enq_v === '0) checkOutput("unexpected_beat_any", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", enq_v, e.data);
`ifdef SERIALIZER_LAST_EN
          checkOutput("beat_last", enq_last, e.last);
`endif
        end
        beat_cyc.push_back(cyc);
        beats_seen++;
      end
    end
  end

  initial begin
    logic [IN_W-1:0] w;
    int base;
    nrst    = 1'b0;
    enq_rdy = 1'b1;

    // Hold reset with a word already waiting upstream; nothing may move.
    applyStimulus(128'h44444444_33333333_22222222_11111111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_deq_ena", deq_ena, 0);
      checkOutput("reset_enq_ena", enq_ena, 0);
    end
    checkOutput("reset_enq_v", enq_v, 0);
    nextCycle();
    nrst = 1'b1;
    $display("[TB] single word");
    waitBeats(4, 20);
    checkOutput("single_first_latency", beat_cyc[0], deq_cyc[0] + 1);
    checkOutput("single_consecutive", beat_cyc[3] - beat_cyc[0], 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("single_back_idle", enq_ena, 0);
    end

    $display("[TB] back-to-back words");
    nextCycle();
    beat_cyc.delete();
    deq_cyc.delete();
    base = beats_seen;
    applyStimulus(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    applyStimulus(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
    applyStimulus(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    waitBeats(base + 12, 40);
    checkOutput("b2b_deq_count", deq_cyc.size(), 3);
    checkOutput("b2b_deq_1", deq_cyc[1] - deq_cyc[0], 4);
    checkOutput("b2b_deq_2", deq_cyc[2] - deq_cyc[0], 8);
    checkOutput("b2b_first_latency", beat_cyc[0], deq_cyc[0] + 1);
    checkOutput("b2b_no_gap", beat_cyc[11] - beat_cyc[0], 11);

    $display("[TB] backpressure");
    nextCycle();
    base = beats_seen;
    applyStimulus(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
    applyStimulus(128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0);
    waitBeats(base + 2, 20);
    enq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_enq_ena", enq_ena, 0);
      checkOutput("stall_deq_ena", deq_ena, 0);
      checkOutput("stall_hold_v", enq_v, 32'hD2D2D2D2);
    end
    nextCycle();
    enq_rdy = 1'b1;
    waitBeats(base + 8, 30);

    $display("[TB] reset mid-word");
    nextCycle();
    base = beats_seen;
    applyStimulus(128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0);
    waitBeats(base + 2, 20);
    nrst = 1'b0;
    checkOutput("flush_depth", exp_q.size(), 2);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midreset_enq_ena", enq_ena, 0);
      checkOutput("midreset_deq_ena", deq_ena, 0);
    end
    nextCycle();
    nrst = 1'b1;
    applyStimulus(128'h97979797_96969696_95959595_94949494);
    waitBeats(base + 6, 20);

    $display("[TB] random ready on both sides");
    nextCycle();
    base = beats_seen;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(w);
    end
    waitBeats(base + 4000, 60000);
    rand_mode = 1'b0;
    up_en     = 1'b1;
    enq_rdy   = 1'b1;
    repeat (3) nextCycle();
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
